// File: rtl/counter_match_game.sv
// Counter-match game core: steer an N-digit BCD counter onto a loaded target before time runs out.
// Optional build macro SCORE_PENALTY_EN: losing a round costs one point (saturating at zero).
module counter_match_game #(
    parameter int unsigned DIGITS     = 2,
    parameter int unsigned ROUND_SECS = 10,
    parameter int unsigned SCORE_W    = 8
) (
    input  logic                  Clk100M,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  start,
    input  logic                  userUp,
    input  logic                  userDown,
    input  logic [4*DIGITS-1:0]   target,
    output logic [4*DIGITS-1:0]   count,
    output logic [7:0]            time_left,
    output logic [1:0]            state,
    output logic [SCORE_W-1:0]    score,
    output logic                  round_done
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StPlay = 2'b01,
        StWin  = 2'b10,
        StLose = 2'b11
    } state_e;

    state_e                r_state, w_state_d;
    logic [4*DIGITS-1:0]   r_count, w_count_d;
    logic [4*DIGITS-1:0]   r_target, w_target_d;
    logic [7:0]            r_time_left, w_time_left_d;
    logic [SCORE_W-1:0]    r_score, w_score_d;
    logic                  r_moved, w_moved_d;
    logic                  r_round_done, w_round_done_d;

    logic [4*DIGITS-1:0]   w_count_inc, w_count_dec, w_target_clamped;
    logic                  w_match;

    // Ripple the carry/borrow digit by digit; all-9s and all-0s wrap naturally.
    always_comb begin
        logic carry;
        logic borrow;
        carry       = 1'b1;
        borrow      = 1'b1;
        w_count_inc = r_count;
        w_count_dec = r_count;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (r_count[4*i +: 4] >= 4'd9) begin
                    w_count_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_count_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (r_count[4*i +: 4] == 4'd0) begin
                    w_count_dec[4*i +: 4] = 4'd9;
                end else begin
                    w_count_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_target_clamped = target;
        for (int i = 0; i < DIGITS; i++) begin
            if (target[4*i +: 4] > 4'd9) begin
                w_target_clamped[4*i +: 4] = 4'd9;
            end
        end
    end

    assign w_match = r_moved && (r_count == r_target);

    always_comb begin
        w_state_d      = r_state;
        w_count_d      = r_count;
        w_target_d     = r_target;
        w_time_left_d  = r_time_left;
        w_score_d      = r_score;
        w_moved_d      = r_moved;
        w_round_done_d = 1'b0;
        unique case (r_state)
            StPlay: begin
                if (userUp && !userDown) begin
                    w_count_d = w_count_inc;
                    w_moved_d = 1'b1;
                end else if (userDown && !userUp) begin
                    w_count_d = w_count_dec;
                    w_moved_d = 1'b1;
                end
                if (tick && (r_time_left != 8'd0)) begin
                    w_time_left_d = r_time_left - 8'd1;
                end
                // A match outranks a simultaneous expiry.
                if (w_match) begin
                    w_state_d      = StWin;
                    w_round_done_d = 1'b1;
                    if (!(&r_score)) begin
                        w_score_d = r_score + 1'b1;
                    end
                end else if (tick && (r_time_left == 8'd1)) begin
                    w_state_d      = StLose;
                    w_round_done_d = 1'b1;
`ifdef SCORE_PENALTY_EN
                    if (r_score != '0) begin
                        w_score_d = r_score - 1'b1;
                    end
`else
                    w_score_d = r_score;
`endif
                end
            end
            default: begin
                if (start) begin
                    w_state_d     = StPlay;
                    w_count_d     = '0;
                    w_time_left_d = 8'(ROUND_SECS);
                    w_moved_d     = 1'b0;
                    w_target_d    = w_target_clamped;
                end
            end
        endcase
    end

    always_ff @(posedge Clk100M) begin
        if (reset) begin
            r_state      <= StIdle;
            r_count      <= '0;
            r_target     <= '0;
            r_time_left  <= 8'd0;
            r_score      <= '0;
            r_moved      <= 1'b0;
            r_round_done <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_count      <= w_count_d;
            r_target     <= w_target_d;
            r_time_left  <= w_time_left_d;
            r_score      <= w_score_d;
            r_moved      <= w_moved_d;
            r_round_done <= w_round_done_d;
        end
    end

    assign count      = r_count;
    assign time_left  = r_time_left;
    assign state      = r_state;
    assign score      = r_score;
    assign round_done = r_round_done;

endmodule

// File: tb/tb_counter_match_game.sv
// Randomised bench for counter_match_game: an integer-arithmetic game model predicts every output.
module tb_counter_match_game;

    localparam int DIGITS     = 2;
    localparam int ROUND_SECS = 3;
    localparam int SCORE_W    = 8;
    localparam int MOD        = 100;

    logic                Clk100M = 1'b0;
    logic                reset, tick, start, userUp, userDown;
    logic [4*DIGITS-1:0] target;
    logic [4*DIGITS-1:0] count;
    logic [7:0]          time_left;
    logic [1:0]          state;
    logic [SCORE_W-1:0]  score;
    logic                round_done;

    always #5 Clk100M = ~Clk100M;

    counter_match_game #(
        .DIGITS     (DIGITS),
        .ROUND_SECS (ROUND_SECS),
        .SCORE_W    (SCORE_W)
    ) dut (
        .Clk100M    (Clk100M),
        .reset      (reset),
        .tick       (tick),
        .start      (start),
        .userUp     (userUp),
        .userDown   (userDown),
        .target     (target),
        .count      (count),
        .time_left  (time_left),
        .state      (state),
        .score      (score),
        .round_done (round_done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Game model: plain integers, state numbered 0 idle, 1 play, 2 win, 3 lose.
    int m_state, m_count, m_time, m_score, m_target;
    bit m_moved, m_done;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int clamp_target(input logic [4*DIGITS-1:0] tg);
        int val, mul, d;
        val = 0;
        mul = 1;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'(tg[4*i +: 4]);
            if (d > 9) d = 9;
            val += d * mul;
            mul *= 10;
        end
        return val;
    endfunction

    task automatic model_update(input bit rst, input bit tk, input bit st, input bit up,
                                input bit dn, input logic [4*DIGITS-1:0] tg);
        bit match, expire;
        if (rst) begin
            m_state = 0; m_count = 0; m_time = 0; m_score = 0;
            m_target = 0; m_moved = 0; m_done = 0;
            return;
        end
        m_done = 0;
        if (m_state == 1) begin
            match  = m_moved && (m_count == m_target);
            expire = tk && (m_time == 1);
            if (up && !dn) begin
                m_count = (m_count + 1) % MOD;
                m_moved = 1;
            end else if (dn && !up) begin
                m_count = (m_count + MOD - 1) % MOD;
                m_moved = 1;
            end
            if (tk && m_time > 0) m_time--;
            if (match) begin
                m_state = 2;
                m_done  = 1;
                if (m_score < (1 << SCORE_W) - 1) m_score++;
            end else if (expire) begin
                m_state = 3;
                m_done  = 1;
`ifdef SCORE_PENALTY_EN
                if (m_score > 0) m_score--;
`endif
            end
        end else if (st) begin
            m_state  = 1;
            m_count  = 0;
            m_time   = ROUND_SECS;
            m_moved  = 0;
            m_target = clamp_target(tg);
        end
    endtask

    task automatic step(input bit rst, input bit tk, input bit st, input bit up, input bit dn,
                        input logic [4*DIGITS-1:0] tg);
        reset = rst; tick = tk; start = st; userUp = up; userDown = dn; target = tg;
        @(posedge Clk100M);
        model_update(rst, tk, st, up, dn, tg);
        #1;
        check_eq("count", 32'(count), to_bcd(m_count));
        check_eq("time_left", 32'(time_left), 32'(m_time));
        check_eq("state", 32'(state), 32'(m_state));
        check_eq("score", 32'(score), 32'(m_score));
        check_eq("round_done", 32'(round_done), 32'(m_done));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, '0);
    endtask

    logic [4*DIGITS-1:0] rnd_tg;

    initial begin
        reset = 1; tick = 0; start = 0; userUp = 0; userDown = 0; target = '0;
        step(1, 0, 0, 0, 0, '0);
        step(1, 0, 0, 0, 0, '0);

        // Win by counting up to 05.
        step(0, 0, 1, 0, 0, 8'h05);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, '0);
        idle(2);
        check_eq("win_state", 32'(state), 32'd2);
        check_eq("win_score", 32'(score), 32'd1);

        // Lose on the third tick.
        step(0, 0, 1, 0, 0, 8'h42);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 0, '0);
            idle(1);
        end
        check_eq("lose_state", 32'(state), 32'd3);
        check_eq("lose_time", 32'(time_left), 32'd0);

        // Wrap down to 99, then wrap 99 up to 00.
        step(0, 0, 1, 0, 0, 8'h99);
        step(0, 0, 0, 0, 1, '0);
        idle(2);
        step(0, 0, 1, 0, 0, 8'h00);
        step(0, 0, 0, 0, 1, '0);
        step(0, 0, 0, 1, 0, '0);
        idle(2);

        // Simultaneous presses do nothing and do not arm the match.
        step(0, 0, 1, 0, 0, 8'h00);
        step(0, 0, 0, 1, 1, '0);
        idle(3);
        check_eq("pair_no_win", 32'(state), 32'd1);
        step(0, 0, 0, 1, 0, '0);
        step(0, 0, 0, 0, 1, '0);
        idle(2);

        // Match seen in the same cycle as the final tick: win.
        step(0, 0, 1, 0, 0, 8'h01);
        step(0, 1, 0, 0, 0, '0);
        step(0, 1, 0, 0, 0, '0);
        step(0, 0, 0, 1, 0, '0);
        step(0, 1, 0, 0, 0, '0);
        check_eq("race_win", 32'(state), 32'd2);
        idle(1);

        // Clamped target, start ignored in play, reset mid-round.
        step(0, 0, 1, 0, 0, 8'hAF);
        step(0, 0, 0, 0, 1, '0);
        idle(2);
        step(0, 0, 1, 0, 0, 8'h3A);
        step(0, 0, 0, 1, 0, '0);
        step(0, 0, 1, 0, 0, 8'h00);
        idle(1);
        step(1, 0, 0, 0, 0, '0);
        check_eq("reset_score", 32'(score), 32'd0);
        idle(2);

        // Random play: sparse ticks so rounds last, targets biased near wrap points.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 1) == 0) rnd_tg = 8'($urandom_range(0, 255));
            else if ($urandom_range(0, 1) == 0) rnd_tg = 8'($urandom_range(0, 3));
            else rnd_tg = 8'(8'h96 + $urandom_range(0, 3));
            step(($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) == 0),
                 rnd_tg);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/counter_match_game.md
Name: counter_match_game

Overview:
- Parametrised successor to the single-counter game core.
- The player steers an N-digit BCD counter with up/down blips to match a loaded target before a countdown (driven by the 1 Hz tick) expires.
- Tracks win/lose state and a running score.
- Sits between the button blip logic (userUp/userDown) and the display mux.
- Outputs the BCD count and time-left for the seg digits.

Parameters:
- DIGITS, 2: number of BCD digits in counter and target (1..4).
- ROUND_SECS, 10: seconds per round (1..255).
- SCORE_W, 8: score register width.

Ports:
- Clk100M  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  one-cycle pulse at 1 Hz, synchronous to Clk100M
- start  in  1  one-cycle pulse; begins a round
- userUp  in  1  one-cycle increment blip
- userDown  in  1  one-cycle decrement blip
- target  in  4*DIGITS  BCD target, sampled on accepted start
- count  out  4*DIGITS  player counter, BCD
- time_left  out  8  seconds remaining
- state  out  2  00 IDLE, 01 PLAY, 10 WIN, 11 LOSE
- score  out  SCORE_W  rounds won
- round_done  out  1  one-cycle pulse on entry to WIN or LOSE

Behaviour:
- Reset (synchronous, takes priority over all inputs):
  - state=IDLE; count=0; time_left=0; score=0; round_done=0.
  - Internal target_q=0; moved flag=0.
  - Reset mid-round aborts the round with no round_done pulse.
- Accepted start (in IDLE, WIN or LOSE):
  - Next cycle: state=PLAY, count=0, time_left=ROUND_SECS, moved=0.
  - target_q=target, with each digit >9 clamped to 9.
  - start during PLAY is ignored.
- PLAY counter update, one-cycle latency from blip to count:
  - userUp alone: BCD +1 with digit carry; all-9s wraps to all-0s.
  - userDown alone: BCD -1 with borrow; all-0s wraps to all-9s.
  - userUp and userDown in the same cycle: no change, moved unaffected.
  - Any accepted single press sets moved=1.
- PLAY countdown: tick decrements time_left by 1; never decrements below 0.
- PLAY win check, on registered values each cycle:
  - match = moved && (count == target_q).
  - match -> WIN next cycle; score+1, saturating at all-ones.
  - Else tick && time_left==1 -> LOSE next cycle; time_left becomes 0.
  - Match and expiry in the same cycle: WIN has priority.
  - A press in the same cycle as a match is still applied to count, but the state change is already committed.
- WIN/LOSE:
  - count, time_left and score hold; blips and ticks are ignored.
  - round_done=1 for exactly the first cycle in WIN or LOSE.
- IDLE: blips and ticks are ignored; all outputs hold.
- tick, start, userUp and userDown are assumed single-cycle pulses; no internal edge detection.

Optional Feature:
SCORE_PENALTY_EN
- Defined: entry to LOSE decrements score by 1, saturating at 0.
- Undefined: score is unchanged on LOSE.

Test Plan (DIGITS=2, ROUND_SECS=3, SCORE_W=8):
- Reset, then start with target=0x05, then five userUp blips -> count steps 01..05; state=WIN one cycle after count=05; score=1; round_done pulses once.
- Start with target=0x42; three ticks, no presses -> time_left 3,2,1,0; state=LOSE on the third tick; round_done pulses; score unchanged (decrements to 0-saturate if SCORE_PENALTY_EN).
- Start with target=0x99; one userDown -> count=0x99 via wrap, then WIN; from count=0x99, userUp -> 0x00.
- userUp and userDown asserted in the same cycle in PLAY -> count unchanged, moved stays 0; start with target=0x00 and no press -> no WIN until after a press pair returns count to 00.
- Final press to match lands in the cycle before the tick with time_left=1 -> WIN, not LOSE.
- Target digit 0xA/0xF -> clamped to 9; reset asserted mid-PLAY -> IDLE, score=0, no round_done; start during PLAY -> ignored.
